fact_engine_param: RTL and testbench

Parametrised iterative factorial engine, the next-generation successor to the fixed 4-bit/32-bit factorial unit. It computes n! for an IN_W-bit operand into an OUT_W-bit result and detects overflow arithmetically rather than with a fixed operand threshold. It adds an edge-triggered start, an abort input and a busy flag. It sits behind the same go/Done/Error/CS handshake used by the SoC's memory-mapped factorial wrapper, which reads CS for debug.

---
 rtl/fact_engine_param.sv | 115 +++++++++++
 tb/tb_fact_engine_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fact_engine_param.sv
// Iterative factorial engine: n! for an IN_W-bit operand into an OUT_W-bit result,
// with edge-triggered start, abort, busy flag and arithmetic overflow detection.
module fact_engine_param #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [IN_W-1:0]  in,
  output logic             Done,
  output logic             Error,
  output logic [1:0]       CS,
  output logic             busy,
  output logic [OUT_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t                  state, state_next;
  logic                    go_q;
  logic [IN_W-1:0]         n_reg, n_next;
  logic [IN_W-1:0]         cnt, cnt_next;
  logic [OUT_W-1:0]        prod, prod_next;
  logic                    done_next, error_next;
  logic [OUT_W-1:0]        result_next;
  logic [OUT_W+IN_W-1:0]   full;
  logic                    start;

  assign start = go && !go_q && ((state == IDLE) || (state == DONE));
  assign full  = {{IN_W{1'b0}}, prod} * {{OUT_W{1'b0}}, cnt};
  assign CS    = state;
  assign busy  = (state == LOAD) || (state == MULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      go_q   <= 1'b0;
      n_reg  <= '0;
      cnt    <= '0;
      prod   <= '0;
      Done   <= 1'b0;
      Error  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      go_q   <= go;
      n_reg  <= n_next;
      cnt    <= cnt_next;
      prod   <= prod_next;
      Done   <= done_next;
      Error  <= error_next;
      result <= result_next;
    end
  end

  always_comb begin
    state_next  = state;
    n_next      = n_reg;
    cnt_next    = cnt;
    prod_next   = prod;
    done_next   = Done;
    error_next  = Error;
    result_next = result;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          n_next     = in;
          done_next  = 1'b0;
          error_next = 1'b0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b0;
          error_next = 1'b0;
        end else begin
          cnt_next   = n_reg;
          prod_next  = OUT_W'(1);
          state_next = MULT;
        end
      end
      MULT: begin
        // abort takes priority over completion and overflow on the same edge
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b0;
          error_next = 1'b0;
        end else if ((cnt >> 1) == '0) begin
          state_next  = DONE;
          result_next = prod;
          done_next   = 1'b1;
        end else if (|full[OUT_W+IN_W-1:OUT_W]) begin
          state_next  = DONE;
          result_next = '0;
          error_next  = 1'b1;
          done_next   = 1'b1;
        end else begin
          prod_next = full[OUT_W-1:0];
          cnt_next  = cnt - IN_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fact_engine_param.sv
// Directed bench for fact_engine_param: default 4/32 instance plus a 5/64 instance.
module tb_fact_engine_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        go_a, abort_a, go_b, abort_b;
  logic [3:0]  in_a;
  logic [4:0]  in_b;
  logic        done_a, error_a, busy_a, done_b, error_b, busy_b;
  logic [1:0]  cs_a, cs_b;
  logic [31:0] result_a;
  logic [63:0] result_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fact_engine_param dut_a (
    .clk(clk), .rst(rst), .go(go_a), .abort(abort_a), .in(in_a),
    .Done(done_a), .Error(error_a), .CS(cs_a), .busy(busy_a), .result(result_a)
  );

  fact_engine_param #(.IN_W(5), .OUT_W(64)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .abort(abort_b), .in(in_b),
    .Done(done_b), .Error(error_b), .CS(cs_b), .busy(busy_b), .result(result_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input string tag, input logic [3:0] n, input logic [31:0] exp_res,
                       input logic exp_err, input int exp_lat);
    int cyc;
    logic [1:0] cs_k1;
    go_a = 1'b1;
    in_a = n;
    tick();
    go_a = 1'b0;
    check({tag, ".cs_load"}, 64'(cs_a), 64'd1);
    check({tag, ".done_clr"}, 64'(done_a), 64'd0);
    check({tag, ".busy"}, 64'(busy_a), 64'd1);
    cyc = 0;
    cs_k1 = 2'b00;
    while (!done_a && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) cs_k1 = cs_a;
    end
    check({tag, ".cs_mult"}, 64'(cs_k1), 64'd2);
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".result"}, 64'(result_a), 64'(exp_res));
    check({tag, ".error"}, 64'(error_a), 64'(exp_err));
    check({tag, ".cs_done"}, 64'(cs_a), 64'd3);
    check({tag, ".busy_low"}, 64'(busy_a), 64'd0);
  endtask

  task automatic run_b(input string tag, input logic [4:0] n, input logic [63:0] exp_res,
                       input logic exp_err, input int exp_lat);
    int cyc;
    go_b = 1'b1;
    in_b = n;
    tick();
    go_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".result"}, result_b, exp_res);
    check({tag, ".error"}, 64'(error_b), 64'(exp_err));
    check({tag, ".cs_done"}, 64'(cs_b), 64'd3);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    go_a = 1'b0; abort_a = 1'b0; in_a = '0;
    go_b = 1'b0; abort_b = 1'b0; in_b = '0;
    #2;
    check("rst.done", 64'(done_a), 64'd0);
    check("rst.error", 64'(error_a), 64'd0);
    check("rst.cs", 64'(cs_a), 64'd0);
    check("rst.busy", 64'(busy_a), 64'd0);
    check("rst.result", 64'(result_a), 64'd0);
    check("rst.result_b", result_b, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_a("n5", 4'd5, 32'd120, 1'b0, 6);
    run_a("n12", 4'd12, 32'h1C8C_FC00, 1'b0, 13);
    run_a("n13", 4'd13, 32'd0, 1'b1, 13);
    run_a("n0", 4'd0, 32'd1, 1'b0, 2);
    run_a("n1", 4'd1, 32'd1, 1'b0, 2);
    run_a("n15", 4'd15, 32'd0, 1'b1, 11);

    // go held high through completion must not retrigger
    go_a = 1'b1;
    in_a = 4'd4;
    tick();
    cyc = 0;
    while (!done_a && cyc < 100) begin
      tick();
      cyc++;
    end
    check("hold.latency", 64'(cyc), 64'd5);
    check("hold.result", 64'(result_a), 64'd24);
    repeat (5) tick();
    check("hold.cs", 64'(cs_a), 64'd3);
    check("hold.done", 64'(done_a), 64'd1);
    go_a = 1'b0;
    tick();
    run_a("n3", 4'd3, 32'd6, 1'b0, 4);

    // abort mid-MULT
    go_a = 1'b1;
    in_a = 4'd10;
    tick();
    go_a = 1'b0;
    repeat (4) tick();
    check("abort.pre_cs", 64'(cs_a), 64'd2);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort.cs", 64'(cs_a), 64'd0);
    check("abort.done", 64'(done_a), 64'd0);
    check("abort.error", 64'(error_a), 64'd0);
    check("abort.result", 64'(result_a), 64'd6);
    check("abort.busy", 64'(busy_a), 64'd0);

    // abort in DONE is ignored
    run_a("n2", 4'd2, 32'd2, 1'b0, 3);
    abort_a = 1'b1;
    tick();
    tick();
    abort_a = 1'b0;
    check("abort_done.cs", 64'(cs_a), 64'd3);
    check("abort_done.done", 64'(done_a), 64'd1);
    check("abort_done.result", 64'(result_a), 64'd2);

    // asynchronous reset between edges during MULT
    go_a = 1'b1;
    in_a = 4'd10;
    tick();
    go_a = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst.cs", 64'(cs_a), 64'd0);
    check("arst.done", 64'(done_a), 64'd0);
    check("arst.error", 64'(error_a), 64'd0);
    check("arst.busy", 64'(busy_a), 64'd0);
    check("arst.result", 64'(result_a), 64'd0);
    #1;
    rst = 1'b1;
    run_a("n4", 4'd4, 32'd24, 1'b0, 5);

    run_b("w64.n20", 5'd20, 64'd2432902008176640000, 1'b0, 21);
    run_b("w64.n21", 5'd21, 64'd0, 1'b1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
